// File: rtl/register_writeback_arbiter.sv
// Arbitrates the single register-file write port between the ALU and LSU writeback
// sources: LSU wins by default, a starvation counter forces an ALU win after STARVE_LIMIT losses.
module register_writeback_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter bit          DROP_X0      = 1'b1,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_wb_valid,
  output logic                 alu_wb_ready,
  input  logic [4:0]           alu_wb_address,
  input  logic [31:0]          alu_wb_data,
  input  logic                 lsu_wb_valid,
  output logic                 lsu_wb_ready,
  input  logic [4:0]           lsu_wb_address,
  input  logic [31:0]          lsu_wb_data,
  output logic                 register_write_enable,
  output logic [4:0]           register_write_address,
  output logic [31:0]          register_write_data,
  output logic [CNT_WIDTH-1:0] conflict_count
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_ALU,
    GRANT_LSU
  } grant_e;

  grant_e               grant;
  logic [4:0]           grant_addr;
  logic [31:0]          grant_data;

  logic [SW-1:0]        starve_q,     starve_d;
  logic                 we_q,         we_d;
  logic [4:0]           addr_q,       addr_d;
  logic [31:0]          data_q,       data_d;
  logic [CNT_WIDTH-1:0] conflict_q,   conflict_d;

  // Grant decision uses only the valids and the starvation count, never the payloads.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    grant = GRANT_NONE;
    if (!rst) begin
      if (alu_wb_valid && lsu_wb_valid) begin
        grant = (starve_q == SW'(STARVE_LIMIT)) ? GRANT_ALU : GRANT_LSU;
      end else if (alu_wb_valid) begin
        grant = GRANT_ALU;
      end else if (lsu_wb_valid) begin
        grant = GRANT_LSU;
      end
    end
  end

  assign alu_wb_ready = (grant == GRANT_ALU);
  assign lsu_wb_ready = (grant == GRANT_LSU);

  always_comb begin
    grant_addr = lsu_wb_address;
    grant_data = lsu_wb_data;
    if (grant == GRANT_ALU) begin
      grant_addr = alu_wb_address;
      grant_data = alu_wb_data;
    end
  end

  always_comb begin
    starve_d   = starve_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    conflict_d = conflict_q;

    if (grant == GRANT_ALU) begin
      starve_d = '0;
    end else if (alu_wb_valid && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end

    // x0 writes still complete the handshake; only the strobe is suppressed.
    if (grant != GRANT_NONE) begin
      we_d   = !(DROP_X0 && (grant_addr == 5'd0));
      addr_d = grant_addr;
      data_d = grant_data;
    end

    if (alu_wb_valid && lsu_wb_valid && (conflict_q != '1)) begin
      conflict_d = conflict_q + CNT_WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments; the data register is reset too
  // because its reset value is architecturally visible on register_write_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q   <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      conflict_q <= '0;
    end else begin
      starve_q   <= starve_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      conflict_q <= conflict_d;
    end
  end

  assign register_write_enable  = we_q;
  assign register_write_address = addr_q;
  assign register_write_data    = data_q;
  assign conflict_count         = conflict_q;

endmodule
